// File: rtl/ahfp_pipeline_arbiter.sv
// Round-robin issue of two requesters into a fixed-latency, non-stallable pipeline,
// with valid/tag slot tracking, credit limiting and a tagged in-order result FIFO.
module ahfp_pipeline_arbiter #(
    parameter int LATENCY    = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             a_valid,
    output logic                             a_ready,
    input  logic [31:0]                      a_data,
    input  logic                             b_valid,
    output logic                             b_ready,
    input  logic [31:0]                      b_data,
    output logic [31:0]                      pipe_in,
    input  logic [31:0]                      pipe_out,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [31:0]                      res_data,
    output logic                             res_id,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  inflight,
    output logic                             busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic          GRANT_A  = 1'b0;
    localparam logic          GRANT_B  = 1'b1;

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] tag;
    logic               last_grant;
    logic [32:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      fifo_count;
    logic               can_issue;
    logic               grant_a;
    logic               grant_b;
    logic               issue;
    logic               capture;
    logic               pop;

    // Credits count results that already own a FIFO entry or will need one.
    assign can_issue = ({1'b0, inflight} + {1'b0, fifo_count}) < CREDITS;
    assign grant_a   = a_valid & (~b_valid | (last_grant == GRANT_B));
    assign grant_b   = b_valid & (~a_valid | (last_grant == GRANT_A));
    assign a_ready   = can_issue & grant_a;
    assign b_ready   = can_issue & grant_b;
    assign issue     = a_ready | b_ready;
    assign pipe_in   = a_ready ? a_data : (b_ready ? b_data : 32'h0);

    assign capture   = vld[LATENCY-1];
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid & res_ready;
    assign res_data  = res_valid ? mem[rd_ptr][31:0] : 32'h0;
    assign res_id    = res_valid & mem[rd_ptr][32];
    assign busy      = (inflight != '0) | res_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld        <= '0;
            tag        <= '0;
            last_grant <= GRANT_B;
            inflight   <= '0;
        end else begin
            vld <= {vld[LATENCY-2:0], issue};
            tag <= {tag[LATENCY-2:0], grant_b};
            if (issue) begin
                last_grant <= grant_b;
            end
            if (issue && !capture) begin
                inflight <= inflight + 1'b1;
            end else if (!issue && capture) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    // Storage is left unreset; the head is masked by res_valid instead.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= {tag[LATENCY-1], pipe_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && (fifo_count == FULL)));

endmodule
